// File: rtl/tri_serializer.sv
// tri_serializer: buffers 144-bit triangles in a FIFO and shifts each out MSB-first
// on nine serial lines under a 16-cycle START window, then waits for DONE.
module tri_serializer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 2000000
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [143:0] TRI_DATA,
   input  logic         TRI_VALID,
   output logic         TRI_READY,
   input  logic         DONE,
   output logic         START,
   output logic         V0X,
   output logic         V0Y,
   output logic         C0,
   output logic         V1X,
   output logic         V1Y,
   output logic         C1,
   output logic         V2X,
   output logic         V2Y,
   output logic         C2,
   output logic         BUSY,
   output logic [15:0]  TRI_COUNT,
   output logic         ERR
);
   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_DONE} state_t;

   state_t            r_state, w_nxt;
   logic [143:0]      r_mem [DEPTH];
   logic [AW:0]       r_wr, r_rd, w_wr_nxt, w_rd_nxt;
   logic [8:0][15:0]  r_sh;
   logic [3:0]        r_bit;
   logic [WW-1:0]     r_wait;
   logic [15:0]       r_cnt;
   logic              r_ready, r_busy, r_start, r_err;
   logic              w_push, w_pop, w_empty, w_full_nxt, w_done_ok, w_timeout;

   assign w_empty    = r_wr == r_rd;
   assign w_push     = TRI_VALID && r_ready;
   assign w_wr_nxt   = r_wr + (AW+1)'(w_push);
   assign w_rd_nxt   = r_rd + (AW+1)'(w_pop);
   assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) && (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

   always_comb begin
      w_nxt     = r_state;
      w_pop     = 1'b0;
      w_done_ok = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         IDLE: begin
            w_pop = !w_empty;
            w_nxt = w_empty ? IDLE : SHIFT;
         end
         SHIFT: w_nxt = (r_bit == 4'hF) ? WAIT_DONE : SHIFT;
         WAIT_DONE: begin
            w_done_ok = DONE;
            w_timeout = !DONE && (r_wait == TO_LAST);
            w_nxt     = (w_done_ok || w_timeout) ? IDLE : WAIT_DONE;
         end
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr[AW-1:0]] <= TRI_DATA;
   end

   // Shift registers drain to zero, so the serial lines are quiet outside SHIFT.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_wr    <= '0;
         r_rd    <= '0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_start <= 1'b0;
         r_sh    <= '0;
         r_bit   <= '0;
         r_wait  <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_wr    <= w_wr_nxt;
         r_rd    <= w_rd_nxt;
         r_ready <= !w_full_nxt;
         r_busy  <= (w_nxt != IDLE) || (w_wr_nxt != w_rd_nxt);
         r_start <= w_nxt == SHIFT;
         r_bit   <= (r_state == SHIFT) ? r_bit + 4'd1 : 4'd0;
         r_wait  <= (r_state == WAIT_DONE) ? r_wait + WW'(1) : '0;
         if (w_pop) r_sh <= r_mem[r_rd[AW-1:0]];
         else for (int i = 0; i < 9; i++) r_sh[i] <= {r_sh[i][14:0], 1'b0};
         if (w_done_ok) r_cnt <= r_cnt + 16'd1;
         if (w_timeout) r_err <= 1'b1;
      end
   end

   assign TRI_READY = r_ready;
   assign BUSY      = r_busy;
   assign START     = r_start;
   assign TRI_COUNT = r_cnt;
   assign ERR       = r_err;
   assign V0X       = r_sh[8][15];
   assign V0Y       = r_sh[7][15];
   assign C0        = r_sh[6][15];
   assign V1X       = r_sh[5][15];
   assign V1Y       = r_sh[4][15];
   assign C1        = r_sh[3][15];
   assign V2X       = r_sh[2][15];
   assign V2Y       = r_sh[1][15];
   assign C2        = r_sh[0][15];
endmodule

// File: tb/tb_tri_serializer.sv
// tb_tri_serializer: directed checks of latency, ordering, backpressure, timeout and reset.
module tb_tri_serializer;
   logic         CLK = 1'b0;
   logic         RST, TRI_VALID, TRI_READY, DONE, START, BUSY, ERR;
   logic         V0X, V0Y, C0, V1X, V1Y, C1, V2X, V2Y, C2;
   logic [143:0] TRI_DATA;
   logic [15:0]  TRI_COUNT;
   logic [8:0]   lines;
   logic [143:0] pq [$];
   int           n_chk = 0, n_fail = 0, exp_cnt = 0;

   tri_serializer #(.DEPTH(4), .TIMEOUT(100)) dut (
      .CLK(CLK), .RST(RST), .TRI_DATA(TRI_DATA), .TRI_VALID(TRI_VALID), .TRI_READY(TRI_READY),
      .DONE(DONE), .START(START), .V0X(V0X), .V0Y(V0Y), .C0(C0), .V1X(V1X), .V1Y(V1Y), .C1(C1),
      .V2X(V2X), .V2Y(V2Y), .C2(C2), .BUSY(BUSY), .TRI_COUNT(TRI_COUNT), .ERR(ERR)
   );

   always #5 CLK = ~CLK;
   assign lines = {V0X, V0Y, C0, V1X, V1Y, C1, V2X, V2Y, C2};

   localparam logic [143:0] T1 = {16'h0280, 16'h0140, 16'hF801, 16'h1234, 16'h5678,
                                  16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hA5A5};

   function automatic logic [143:0] mk(input int s);
      return T1 ^ {9{16'(s * 16'h1111)}};
   endfunction

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      TRI_VALID = pq.size() > 0;
      TRI_DATA  = (pq.size() > 0) ? pq[0] : '0;
   endtask

   task automatic tick();
      logic acc;
      acc = TRI_VALID && TRI_READY;
      @(posedge CLK);
      #1;
      if (acc) pq.delete(0);
      drive();
   endtask

   task automatic done_pulse();
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
   endtask

   task automatic push_start();
      drive();
      tick();
      chk("lat_n1_start_low", START, 0);
      tick();
      chk("lat_n2_start_high", START, 1);
   endtask

   task automatic get_tri(output logic [143:0] d, input int stray);
      int bad;
      bad = 0;
      d = '0;
      for (int k = 0; k < 16; k++) begin
         if (START !== 1'b1) bad++;
         for (int j = 0; j < 9; j++) d[j*16 + 15 - k] = lines[j];
         if (k == stray) DONE = 1'b1;
         tick();
         DONE = 1'b0;
      end
      chk("start_16_cycles", bad, 0);
      chk("start_fall", START, 0);
      chk("lines_idle", lines, 0);
   endtask

   task automatic done_next(input logic [143:0] exp);
      logic [143:0] d;
      repeat (40) tick();
      done_pulse();
      exp_cnt++;
      chk("count_after_done", TRI_COUNT, 16'(exp_cnt));
      chk("gap_start_low", START, 0);
      tick();
      chk("gap_start_high", START, 1);
      get_tri(d, -1);
      chk("order", d, exp);
   endtask

   initial begin
      logic [143:0] d;
      int seen;
      RST = 1'b1; DONE = 1'b0; TRI_VALID = 1'b0; TRI_DATA = '0;
      repeat (2) tick();
      chk("rst_start", START, 0);
      chk("rst_lines", lines, 0);
      chk("rst_ready", TRI_READY, 1);
      chk("rst_busy", BUSY, 0);
      chk("rst_count", TRI_COUNT, 0);
      chk("rst_err", ERR, 0);
      RST = 1'b0;
      tick();

      // single triangle
      pq.push_back(T1);
      push_start();
      get_tri(d, -1);
      chk("single_data", d, T1);
      repeat (5) tick();
      done_pulse();
      exp_cnt++;
      chk("single_count", TRI_COUNT, 16'(exp_cnt));
      chk("single_busy", BUSY, 0);

      // back-to-back
      pq.push_back(mk(1)); pq.push_back(mk(2)); pq.push_back(mk(3));
      push_start();
      get_tri(d, -1);
      chk("b2b_first", d, mk(1));
      done_next(mk(2));
      done_next(mk(3));
      repeat (40) tick();
      done_pulse();
      exp_cnt++;
      chk("b2b_count", TRI_COUNT, 16'(exp_cnt));
      chk("b2b_busy", BUSY, 0);

      // full FIFO with DONE withheld
      pq.push_back(mk(4));
      push_start();
      get_tri(d, -1);
      chk("full_first", d, mk(4));
      for (int i = 5; i < 10; i++) pq.push_back(mk(i));
      drive();
      repeat (4) tick();
      chk("full_ready_low", TRI_READY, 0);
      chk("full_held", pq.size(), 1);
      repeat (3) tick();
      chk("full_ready_still_low", TRI_READY, 0);
      chk("full_still_held", pq.size(), 1);
      done_pulse();
      exp_cnt++;
      chk("full_pop_ready_low", TRI_READY, 0);
      chk("full_pop_start_low", START, 0);
      tick();
      chk("full_ready_after_pop", TRI_READY, 1);
      chk("full_start", START, 1);
      get_tri(d, -1);
      chk("full_order", d, mk(5));
      for (int i = 6; i < 10; i++) done_next(mk(i));
      repeat (40) tick();
      done_pulse();
      exp_cnt++;
      chk("full_count", TRI_COUNT, 16'(exp_cnt));

      // timeout
      pq.push_back(mk(10)); pq.push_back(mk(11));
      push_start();
      get_tri(d, -1);
      chk("to_first", d, mk(10));
      repeat (99) tick();
      chk("to_err_before", ERR, 0);
      tick();
      chk("to_err_set", ERR, 1);
      chk("to_count_same", TRI_COUNT, 16'(exp_cnt));
      chk("to_start_low", START, 0);
      tick();
      chk("to_next_start", START, 1);
      get_tri(d, -1);
      chk("to_next_data", d, mk(11));
      repeat (10) tick();
      done_pulse();
      exp_cnt++;
      chk("to_count_after", TRI_COUNT, 16'(exp_cnt));
      chk("to_err_sticky", ERR, 1);

      // stray DONE in SHIFT and IDLE
      pq.push_back(mk(12));
      push_start();
      get_tri(d, 7);
      chk("stray_data", d, mk(12));
      chk("stray_shift_count", TRI_COUNT, 16'(exp_cnt));
      repeat (5) tick();
      done_pulse();
      exp_cnt++;
      chk("stray_wait_count", TRI_COUNT, 16'(exp_cnt));
      done_pulse();
      chk("stray_idle_count", TRI_COUNT, 16'(exp_cnt));
      chk("stray_idle_busy", BUSY, 0);
      tick();
      chk("stray_idle_start", START, 0);

      // reset mid-shift with triangles queued
      pq.push_back(mk(13)); pq.push_back(mk(14)); pq.push_back(mk(15));
      push_start();
      repeat (9) tick();
      chk("mid_start_k9", START, 1);
      RST = 1'b1;
      tick();
      chk("mid_rst_start", START, 0);
      chk("mid_rst_lines", lines, 0);
      chk("mid_rst_ready", TRI_READY, 1);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_count", TRI_COUNT, 0);
      chk("mid_rst_err", ERR, 0);
      RST = 1'b0;
      pq.delete();
      drive();
      seen = 0;
      repeat (30) begin
         tick();
         if (START !== 1'b0 || BUSY !== 1'b0) seen++;
      end
      chk("mid_no_restart", seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/tri_serializer.md
# tri_serializer

Feeds triangles into the rasterizer's serial input port. Accepts whole triangles as 144-bit parallel words through a valid/ready handshake, buffers them in a small FIFO, and shifts each one out on the nine 1-bit vertex/colour lines with START held high for 16 cycles. It then waits for the rasterizer's DONE pulse before sending the next triangle. Sits between the triangle setup/command logic and the rasterizer.

## Interface

Parameters:

- DEPTH, 4: FIFO entries (power of two, ≥2)
- TIMEOUT, 2000000: maximum cycles to wait for DONE after a triangle is sent

Ports:

- CLK  in  1  clock; single clock domain
- RST  in  1  reset; synchronous, active-high
- TRI_DATA  in  144  packed triangle {x0,y0,c0,x1,y1,c1,x2,y2,c2}; x0 in [143:128], c2 in [15:0]; coordinates Q10.6, colours R5G5B5A1
- TRI_VALID  in  1  TRI_DATA valid
- TRI_READY  out  1  FIFO can accept; equals !full
- DONE  in  1  rasterizer finished current triangle (1-cycle pulse)
- START  out  1  serial data valid; high for exactly 16 consecutive cycles per triangle
- V0X, V0Y, C0, V1X, V1Y, C1, V2X, V2Y, C2  out  1 each  serial lines, MSB first
- BUSY  out  1  high when not in IDLE or FIFO non-empty
- TRI_COUNT  out  16  triangles completed (DONE received), wraps at 65535→0
- ERR  out  1  sticky timeout flag

## Operation

- Push: the entry is written when TRI_VALID && TRI_READY. TRI_READY is derived from the registered occupancy only; a pop in the same cycle does not raise TRI_READY while full.
- FSM states: IDLE, SHIFT, WAIT_DONE.
- IDLE: if FIFO non-empty, pop head, load nine 16-bit shift registers, clear bit counter, go SHIFT. Otherwise stay.
- SHIFT: START=1. Each line drives bit [15−k] of its field on shift cycle k (k=0..15). After k=15, go WAIT_DONE.
- WAIT_DONE: START=0 and all serial lines 0. A wait counter increments each cycle.
  - DONE=1: TRI_COUNT+1, go IDLE.
  - Counter reaches TIMEOUT without DONE: ERR←1, go IDLE; TRI_COUNT unchanged.
- DONE in IDLE or SHIFT is ignored and has no effect on any state.
- Serial lines are 0 whenever START=0.
- ERR is cleared only by RST. Operation continues normally after ERR is set.
- FIFO pointers use log2(DEPTH) bits plus wrap bit. Occupancy is 0..DEPTH. Push and pop in the same cycle leave occupancy unchanged.

## Timing

- Reset values: START=0, all serial lines 0, TRI_READY=1 (FIFO empty), BUSY=0, TRI_COUNT=0, ERR=0, FSM=IDLE, FIFO empty.
- RST mid-SHIFT or mid-WAIT_DONE aborts immediately. START drops the cycle after RST is sampled, and buffered triangles are discarded.
- Latency, push to START: push accepted in cycle n with FSM in IDLE and FIFO empty → popped in n+1 → START=1 in cycles n+2..n+17.
- DONE to next START: DONE sampled in cycle m with FIFO non-empty → IDLE in m+1 (pop) → START=1 from m+2.
- Minimum triangle period: 16 + 2 + DONE latency.
- All outputs are registered.

## Test plan

- Single triangle: push x0=0x0280, y0=0x0140, c0=0xF801, others distinct. Check START high for exactly 16 cycles starting 2 cycles after the push, and that every line reconstructs its field MSB-first. After a DONE pulse, TRI_COUNT=1 and BUSY=0.
- Back-to-back: push 3 triangles, pulse DONE 40 cycles after each START falls. Check the three triangles go out in push order, each next START is 2 cycles after DONE, and TRI_COUNT=3.
- Full FIFO (DEPTH=4), DONE withheld: push 5 triangles while the first is in WAIT_DONE. Check TRI_READY=0 after 4 are buffered and that a TRI_VALID held high is not accepted. After DONE, check TRI_READY=1 the cycle after the pop.
- Timeout (TIMEOUT=100): send a triangle, never assert DONE. Check ERR=1 exactly 100 cycles into WAIT_DONE, TRI_COUNT=0, and that the next queued triangle starts 2 cycles later.
- Stray DONE: pulse DONE during SHIFT cycle 7 and during IDLE. Check no TRI_COUNT change and no state change.
- Reset mid-shift: assert RST at shift cycle 9 with 2 triangles queued. Check all outputs at their reset values the next cycle and no further START without a new push.
